row_window_accum: RTL and testbench

- Parametrised sliding-window accumulator for the convolution datapath. Keeps the last DEPTH accepted row partial sums and outputs their signed sum.
- Adds over the fixed 3-deep version: an input valid handshake, a fill counter, an output valid strobe, a synchronous flush and output saturation.
- Sits between the per-row multiply-add stage and the activation/pooling stage.

---
 rtl/row_window_accum.sv | 102 ++++++++++
 tb/tb_row_window_accum.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/row_window_accum.sv
// Sliding-window accumulator: signed sum of the last DEPTH accepted row partial sums, saturated to OUT_W.
// Optional RELU_EN macro clamps negative saturated results to zero before the output register.
module row_window_accum #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 3,
  parameter int OUT_W  = 16,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int SUM_W = DATA_W + $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  out_data,
  output logic [CNT_W-1:0]         fill_count
);

  localparam int WIDE_W = ((SUM_W > OUT_W) ? SUM_W : OUT_W) + 1;
  localparam logic signed [WIDE_W-1:0] MAX_V = {{(WIDE_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [WIDE_W-1:0] MIN_V = {{(WIDE_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [SUM_W-1:0] v);
    logic signed [WIDE_W-1:0] vw;
    vw = WIDE_W'(v);
    if (vw > MAX_V)      sat_out = $signed(MAX_V[OUT_W-1:0]);
    else if (vw < MIN_V) sat_out = $signed(MIN_V[OUT_W-1:0]);
    else                 sat_out = $signed(vw[OUT_W-1:0]);
  endfunction

  function automatic logic signed [OUT_W-1:0] relu(input logic signed [OUT_W-1:0] v);
    relu = (v < 0) ? '0 : v;
  endfunction

  logic signed [DATA_W-1:0] win_p0 [DEPTH];
  logic signed [DATA_W-1:0] win_nxt [DEPTH];
  logic [CNT_W-1:0]         fill_p0;
  logic [CNT_W-1:0]         fill_nxt;
  logic                     vld_nxt;
  logic                     vld_p0;
  logic signed [SUM_W-1:0]  sum_p0;
  logic signed [OUT_W-1:0]  res_p0;
  logic signed [OUT_W-1:0]  data_p1;
  logic                     vld_p1;

  // clear empties the window first, so a same-cycle sample lands as the only entry
  always_comb begin
    for (int i = 0; i < DEPTH; i++) win_nxt[i] = clear ? '0 : win_p0[i];
    fill_nxt = clear ? '0 : fill_p0;
    if (in_valid) begin
      for (int i = 0; i < DEPTH - 1; i++) win_nxt[i] = clear ? '0 : win_p0[i+1];
      win_nxt[DEPTH-1] = in_data;
      if (fill_nxt != CNT_W'(DEPTH)) fill_nxt = fill_nxt + 1'b1;
    end
    vld_nxt = in_valid && !clear && (fill_nxt == CNT_W'(DEPTH));
  end

  // stage p0: window registers, fill count and full-window flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) win_p0[i] <= '0;
      fill_p0 <= '0;
      vld_p0  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) win_p0[i] <= win_nxt[i];
      fill_p0 <= fill_nxt;
      vld_p0  <= vld_nxt;
    end
  end

  always_comb begin
    sum_p0 = '0;
    for (int i = 0; i < DEPTH; i++) sum_p0 = sum_p0 + SUM_W'(win_p0[i]);
`ifdef RELU_EN
    res_p0 = relu(sat_out(sum_p0));
`else
    res_p0 = sat_out(sum_p0);
`endif
  end

  // stage p1: registered result; a flush suppresses a pending pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0 && !clear;
      if (vld_p0 && !clear) data_p1 <= res_p0;
    end
  end

  assign out_valid  = vld_p1;
  assign out_data   = data_p1;
  assign fill_count = fill_p0;

`ifndef RELU_EN
  logic unused_relu;
  assign unused_relu = ^relu('0);
`endif

endmodule

// File: tb/tb_row_window_accum.sv
// Directed testbench for row_window_accum at DATA_W=16, DEPTH=3, OUT_W=16.
module tb_row_window_accum;
  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               clear = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [15:0] in_data = '0;
  logic               out_valid;
  logic signed [15:0] out_data;
  logic [1:0]         fill_count;
  int vecs = 0;
  int errs = 0;

  row_window_accum #(.DATA_W(16), .DEPTH(3), .OUT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_data(in_data), .out_valid(out_valid), .out_data(out_data), .fill_count(fill_count)
  );

  always #5 clk = ~clk;

  task automatic step(input logic v, input logic signed [15:0] d, input logic c);
    in_valid = v; in_data = d; clear = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_vld got=%0b exp=0", out_valid); end
    vecs++; if (out_data !== 16'sd0) begin errs++; $display("FAIL reset_data got=%0d exp=0", out_data); end
    vecs++; if (fill_count !== 2'd0) begin errs++; $display("FAIL reset_fill got=%0d exp=0", fill_count); end
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic test_stream;
    step(1, 1, 0); step(1, 2, 0);
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL stream_partial got=%0b exp=0", out_valid); end
    step(1, 3, 0);
    vecs++; if (fill_count !== 2'd3) begin errs++; $display("FAIL stream_fill got=%0d exp=3", fill_count); end
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL stream_lat got=%0b exp=0", out_valid); end
    step(1, 4, 0);
    vecs++; if (out_valid !== 1'b1 || out_data !== 16'sd6) begin errs++; $display("FAIL stream_6 got=%0b/%0d exp=1/6", out_valid, out_data); end
    step(1, 5, 0);
    vecs++; if (out_valid !== 1'b1 || out_data !== 16'sd9) begin errs++; $display("FAIL stream_9 got=%0b/%0d exp=1/9", out_valid, out_data); end
    step(0, 0, 0);
    vecs++; if (out_valid !== 1'b1 || out_data !== 16'sd12) begin errs++; $display("FAIL stream_12 got=%0b/%0d exp=1/12", out_valid, out_data); end
    step(0, 0, 0);
    vecs++; if (out_valid !== 1'b0 || out_data !== 16'sd12) begin errs++; $display("FAIL stream_hold got=%0b/%0d exp=0/12", out_valid, out_data); end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 3; i++) step(1, 16'sd32767, 0);
    step(0, 0, 0);
    vecs++; if (out_data !== 16'sd32767) begin errs++; $display("FAIL sat_max got=%0d exp=32767", out_data); end
    for (int i = 0; i < 3; i++) step(1, -16'sd32768, 0);
    step(0, 0, 0);
`ifdef RELU_EN
    vecs++; if (out_data !== 16'sd0) begin errs++; $display("FAIL sat_min got=%0d exp=0", out_data); end
`else
    vecs++; if (out_data !== -16'sd32768) begin errs++; $display("FAIL sat_min got=%0d exp=-32768", out_data); end
`endif
    step(1, 16'sd32767, 0); step(1, 16'sd32767, 0); step(1, -16'sd32768, 0);
    step(0, 0, 0);
    vecs++; if (out_data !== 16'sd32766) begin errs++; $display("FAIL sat_mix got=%0d exp=32766", out_data); end
    step(0, 0, 0);
  endtask

  task automatic test_clear;
    step(0, 0, 1);
    vecs++; if (fill_count !== 2'd0) begin errs++; $display("FAIL clr_fill0 got=%0d exp=0", fill_count); end
    step(1, 5, 0); step(1, 6, 0);
    step(1, 7, 1);
    vecs++; if (fill_count !== 2'd1) begin errs++; $display("FAIL clr_fill1 got=%0d exp=1", fill_count); end
    step(1, 8, 0);
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL clr_noout8 got=%0b exp=0", out_valid); end
    step(1, 9, 0);
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL clr_noout9 got=%0b exp=0", out_valid); end
    step(0, 0, 0);
    vecs++; if (out_valid !== 1'b1 || out_data !== 16'sd24) begin errs++; $display("FAIL clr_24 got=%0b/%0d exp=1/24", out_valid, out_data); end
    vecs++; if (fill_count !== 2'd3) begin errs++; $display("FAIL clr_fill3 got=%0d exp=3", fill_count); end
    step(0, 0, 0);
  endtask

  task automatic test_gaps;
    logic               gv [12] = '{1,0,0,1,0,0,1,0,0,1,0,0};
    logic signed [15:0] gd [12] = '{1,0,0,2,0,0,3,0,0,4,0,0};
    logic               ev [12] = '{0,0,0,0,0,0,0,1,0,0,1,0};
    int pulses = 0;
    step(0, 0, 1);
    for (int i = 0; i < 12; i++) begin
      step(gv[i], gd[i], 0);
      if (out_valid === 1'b1) pulses++;
      vecs++; if (out_valid !== ev[i]) begin errs++; $display("FAIL gap_vld[%0d] got=%0b exp=%0b", i, out_valid, ev[i]); end
      if (i >= 7 && i <= 9) begin
        vecs++; if (out_data !== 16'sd6) begin errs++; $display("FAIL gap_d6[%0d] got=%0d exp=6", i, out_data); end
      end
      if (i >= 10) begin
        vecs++; if (out_data !== 16'sd9) begin errs++; $display("FAIL gap_d9[%0d] got=%0d exp=9", i, out_data); end
      end
    end
    vecs++; if (pulses != 2) begin errs++; $display("FAIL gap_pulses got=%0d exp=2", pulses); end
  endtask

  task automatic test_negative;
    step(0, 0, 1);
    step(1, -16'sd1, 0); step(1, -16'sd2, 0); step(1, -16'sd3, 0);
    step(0, 0, 0);
`ifdef RELU_EN
    vecs++; if (out_valid !== 1'b1 || out_data !== 16'sd0) begin errs++; $display("FAIL neg_relu got=%0b/%0d exp=1/0", out_valid, out_data); end
`else
    vecs++; if (out_valid !== 1'b1 || out_data !== -16'sd6) begin errs++; $display("FAIL neg_sum got=%0b/%0d exp=1/-6", out_valid, out_data); end
`endif
    step(0, 0, 0);
  endtask

  task automatic test_reset_midstream;
    step(0, 0, 1);
    step(1, 1, 0); step(1, 2, 0); step(1, 3, 0);
    step(0, 0, 0);
    vecs++; if (out_valid !== 1'b1 || out_data !== 16'sd6) begin errs++; $display("FAIL rst_pre got=%0b/%0d exp=1/6", out_valid, out_data); end
    #2 rst_n = 1'b0;
    #1;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_vld got=%0b exp=0", out_valid); end
    vecs++; if (out_data !== 16'sd0) begin errs++; $display("FAIL rst_data got=%0d exp=0", out_data); end
    vecs++; if (fill_count !== 2'd0) begin errs++; $display("FAIL rst_fill got=%0d exp=0", fill_count); end
    @(posedge clk); #1; rst_n = 1'b1;
    step(1, 4, 0); step(1, 5, 0);
    vecs++; if (out_valid !== 1'b0 || fill_count !== 2'd2) begin errs++; $display("FAIL rst_refill got=%0b/%0d exp=0/2", out_valid, fill_count); end
    step(1, 6, 0);
    step(0, 0, 0);
    vecs++; if (out_valid !== 1'b1 || out_data !== 16'sd15) begin errs++; $display("FAIL rst_15 got=%0b/%0d exp=1/15", out_valid, out_data); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_saturation();
    test_clear();
    test_gaps();
    test_negative();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
